// File: rtl/sfu_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sfu_lut_loader
//  Purpose  : Streams LUT contents from the CFG/DMA stream into the SFU lookup
//             tables. Broadcasts each entry to a mask of banks and wraps the
//             address modulo LUT_DEPTH. Can optionally read every written bank
//             back and compare a per-bank checksum against the write checksum.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock; asynchronous active-low reset
//    cfg_start / cfg_abort    single-cycle start / abort strobes
//    cfg_base / cfg_len       first address / entry count (0..LUT_DEPTH)
//    cfg_bank_mask            banks written (broadcast)
//    cfg_verify               run readback-verify pass after write
//    s_valid / s_data / s_ready   input data stream
//    lut_wr_*                 LUT write port (registered)
//    lut_rd_*                 LUT read port; lut_rd_data one cycle after en
//    busy / done / aborted    status; done is a one-cycle pulse
//    err / err_bank_mask      verify mismatch, sticky until next start
//    wr_sum                   modulo-2^SUM_W sum of accepted data
// ============================================================================
module sfu_lut_loader #(
  parameter  int LUT_DEPTH = 4096,
  parameter  int ADDR_W    = 12,
  parameter  int DATA_W    = 16,
  parameter  int NUM_BANKS = 2,
  parameter  int SUM_W     = 32,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [ADDR_W:0]      cfg_len,
  input  logic [NUM_BANKS-1:0] cfg_bank_mask,
  input  logic                 cfg_verify,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 s_ready,
  output logic                 lut_wr_en,
  output logic [NUM_BANKS-1:0] lut_wr_mask,
  output logic [ADDR_W-1:0]    lut_wr_addr,
  output logic [DATA_W-1:0]    lut_wr_data,
  output logic                 lut_rd_en,
  output logic [BANK_W-1:0]    lut_rd_bank,
  output logic [ADDR_W-1:0]    lut_rd_addr,
  input  logic [DATA_W-1:0]    lut_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err,
  output logic [NUM_BANKS-1:0] err_bank_mask,
  output logic [SUM_W-1:0]     wr_sum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_FLUSH  = 3'd2,
    S_VERIFY = 3'd3,
    S_VWAIT  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] c_max_len = (ADDR_W+1)'(LUT_DEPTH);
  localparam logic [ADDR_W:0] c_one     = (ADDR_W+1)'(1);

  state_t                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]      r_base;
  logic [ADDR_W:0]        r_len;
  logic [NUM_BANKS-1:0]   r_mask;
  logic                   r_verify;
  logic [ADDR_W:0]        r_cnt;      // beats accepted so far
  logic [ADDR_W:0]        r_ridx;     // read index within current bank
  logic [BANK_W-1:0]      r_bank;     // bank currently being read
  logic                   r_rd_vld;   // lut_rd_data valid this cycle
  logic                   r_rd_last;  // ... and it is the bank's last entry
  logic [BANK_W-1:0]      r_rd_bank;
  logic [SUM_W-1:0]       r_rd_sum;

  logic                   w_start, w_abort, w_accept, w_last_beat, w_rd_last;
  logic [ADDR_W:0]        w_len;
  logic [BANK_W-1:0]      w_nb;
  logic                   w_nb_found;
  logic [SUM_W-1:0]       w_bank_sum;

  // Out-of-range lengths saturate to one full table.
  assign w_len      = (cfg_len > c_max_len) ? c_max_len : cfg_len;
  assign w_start    = (r_state == S_IDLE) && cfg_start;
  assign w_abort    = (r_state != S_IDLE) && cfg_abort;
  assign w_accept   = s_valid && s_ready;
  assign w_last_beat = w_accept && ((r_cnt + c_one) == r_len);
  assign w_rd_last  = lut_rd_en && (r_ridx == (r_len - c_one));
  assign w_bank_sum = r_rd_sum + SUM_W'(lut_rd_data);

  // Next bank to read: in FLUSH the lowest masked bank, in VERIFY the lowest
  // masked bank above the current one (so banks follow back-to-back).
  always_comb begin
    w_nb       = '0;
    w_nb_found = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (r_mask[i] && ((r_state != S_VERIFY) || (i > int'(r_bank)))) begin
        w_nb       = BANK_W'(i);
        w_nb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    s_ready     = (r_state == S_WRITE) && (r_cnt != r_len);
    lut_rd_en   = (r_state == S_VERIFY);
    lut_rd_bank = '0;
    lut_rd_addr = '0;
    if (lut_rd_en) begin
      lut_rd_bank = r_bank;
      lut_rd_addr = r_base + r_ridx[ADDR_W-1:0];
    end
    case (r_state)
      S_IDLE:   if (cfg_start) w_state_nxt = (w_len == '0) ? S_FLUSH : S_WRITE;
      S_WRITE:  if (w_last_beat) w_state_nxt = S_FLUSH;
      S_FLUSH:  w_state_nxt = (r_verify && (r_mask != '0) && (r_len != '0)) ? S_VERIFY : S_DONE;
      S_VERIFY: if (w_rd_last && !w_nb_found) w_state_nxt = S_VWAIT;
      // Leave only once the final read data has been folded into err, so
      // err/err_bank_mask are already stable when done pulses.
      S_VWAIT:  if (!r_rd_vld) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base        <= '0;
      r_len         <= '0;
      r_mask        <= '0;
      r_verify      <= 1'b0;
      r_cnt         <= '0;
      r_ridx        <= '0;
      r_bank        <= '0;
      r_rd_vld      <= 1'b0;
      r_rd_last     <= 1'b0;
      r_rd_bank     <= '0;
      r_rd_sum      <= '0;
      lut_wr_en     <= 1'b0;
      lut_wr_mask   <= '0;
      lut_wr_addr   <= '0;
      lut_wr_data   <= '0;
      aborted       <= 1'b0;
      err           <= 1'b0;
      err_bank_mask <= '0;
      wr_sum        <= '0;
    end else begin
      lut_wr_en   <= 1'b0;
      lut_wr_mask <= '0;

      if (w_start) begin
        r_base        <= cfg_base;
        r_len         <= w_len;
        r_mask        <= cfg_bank_mask;
        r_verify      <= cfg_verify;
        r_cnt         <= '0;
        r_rd_sum      <= '0;
        aborted       <= 1'b0;
        err           <= 1'b0;
        err_bank_mask <= '0;
        wr_sum        <= '0;
      end

      if (w_abort) aborted <= 1'b1;

      // A beat accepted in the abort cycle is counted but never written.
      if (w_accept) begin
        r_cnt <= r_cnt + c_one;
        if (!cfg_abort) begin
          lut_wr_en   <= 1'b1;
          lut_wr_mask <= r_mask;
          lut_wr_addr <= r_base + r_cnt[ADDR_W-1:0];
          lut_wr_data <= s_data;
          wr_sum      <= wr_sum + SUM_W'(s_data);
        end
      end

      if (r_state == S_FLUSH) begin
        r_bank <= w_nb;
        r_ridx <= '0;
      end else if (lut_rd_en) begin
        if (w_rd_last) begin
          r_bank <= w_nb;
          r_ridx <= '0;
        end else begin
          r_ridx <= r_ridx + c_one;
        end
      end

      r_rd_vld  <= lut_rd_en && !cfg_abort;
      r_rd_last <= w_rd_last;
      r_rd_bank <= lut_rd_bank;

      if (r_rd_vld) begin
        if (r_rd_last) begin
          r_rd_sum <= '0;
          if (w_bank_sum != wr_sum) begin
            err                      <= 1'b1;
            err_bank_mask[r_rd_bank] <= 1'b1;
          end
        end else begin
          r_rd_sum <= w_bank_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sfu_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfu_lut_loader
//  Purpose  : Directed self-checking bench for sfu_lut_loader with a
//             two-bank LUT memory model (optionally corrupting one entry).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfu_lut_loader;
  localparam int LUT_DEPTH = 4096;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int NUM_BANKS = 2;
  localparam int SUM_W     = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start, cfg_abort, cfg_verify;
  logic [ADDR_W-1:0]    cfg_base;
  logic [ADDR_W:0]      cfg_len;
  logic [NUM_BANKS-1:0] cfg_bank_mask;
  logic                 s_valid, s_ready;
  logic [DATA_W-1:0]    s_data;
  logic                 lut_wr_en, lut_rd_en;
  logic [NUM_BANKS-1:0] lut_wr_mask;
  logic [ADDR_W-1:0]    lut_wr_addr, lut_rd_addr;
  logic [DATA_W-1:0]    lut_wr_data, lut_rd_data;
  logic [0:0]           lut_rd_bank;
  logic                 busy, done, aborted, err;
  logic [NUM_BANKS-1:0] err_bank_mask;
  logic [SUM_W-1:0]     wr_sum;

  sfu_lut_loader #(
    .LUT_DEPTH(LUT_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NUM_BANKS(NUM_BANKS), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_bank_mask(cfg_bank_mask), .cfg_verify(cfg_verify),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .lut_wr_en(lut_wr_en), .lut_wr_mask(lut_wr_mask), .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data), .lut_rd_en(lut_rd_en), .lut_rd_bank(lut_rd_bank),
    .lut_rd_addr(lut_rd_addr), .lut_rd_data(lut_rd_data),
    .busy(busy), .done(done), .aborted(aborted), .err(err),
    .err_bank_mask(err_bank_mask), .wr_sum(wr_sum)
  );

  always #5 clk = ~clk;

  // ---------------- memory model and activity logs ----------------
  int   cyc = 0;
  logic clr_mon = 1'b0;
  logic corrupt = 1'b0;
  logic [DATA_W-1:0] mem [NUM_BANKS][LUT_DEPTH];
  int wr_addr_q[$], wr_data_q[$], wr_mask_q[$], wr_cyc_q[$];
  int rd_bank_q[$], rd_addr_q[$], rd_cyc_q[$];
  int done_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_mon) begin
      wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete(); wr_cyc_q.delete();
      rd_bank_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete(); done_q.delete();
    end else begin
      if (lut_wr_en) begin
        wr_addr_q.push_back(int'(lut_wr_addr));
        wr_data_q.push_back(int'(lut_wr_data));
        wr_mask_q.push_back(int'(lut_wr_mask));
        wr_cyc_q.push_back(cyc);
        for (int b = 0; b < NUM_BANKS; b++)
          if (lut_wr_mask[b]) mem[b][lut_wr_addr] <= lut_wr_data;
      end
      if (lut_rd_en) begin
        rd_bank_q.push_back(int'(lut_rd_bank));
        rd_addr_q.push_back(int'(lut_rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
    end
    if (lut_rd_en)
      lut_rd_data <= mem[lut_rd_bank][lut_rd_addr] ^
                     ((corrupt && lut_rd_bank == 1'b1 && lut_rd_addr == 12'd5) ? 16'h0001 : 16'h0000);
    else
      lut_rd_data <= '0;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    clr_mon = 1'b1; tick(); clr_mon = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                          input logic [NUM_BANKS-1:0] mask, input logic ver, output int c0);
    cfg_base = base; cfg_len = len; cfg_bank_mask = mask; cfg_verify = ver;
    cfg_start = 1'b1; c0 = cyc;
    tick();
    cfg_start = 1'b0;
  endtask

  // Beat i carries d0 + i*step; toggle=1 drives s_valid only every other cycle.
  task automatic send(input string tag, input int n, input int d0, input int step,
                      input bit toggle, output int k);
    int  i = 0;
    int  t = 0;
    bit  acc;
    k = -1;
    while (i < n && t < 3 * n + 20) begin
      s_valid = toggle ? ((t % 2) == 0) : 1'b1;
      s_data  = DATA_W'(d0 + i * step);
      acc     = s_valid && s_ready;
      tick();
      if (acc) begin k = cyc - 1; i++; end
      t++;
    end
    s_valid = 1'b0;
    check({tag, "_beats"}, i, n);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 200; t++) begin
      if (done) begin dc = cyc; break; end
      tick();
    end
    tick();
  endtask

  int c0, k, dc, errs;
  logic [31:0] exp_sum;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_start = 0; cfg_abort = 0; cfg_verify = 0;
    cfg_base = '0; cfg_len = '0; cfg_bank_mask = '0; s_valid = 0; s_data = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_sready", s_ready, 0);
    check("rst_wr_en", lut_wr_en, 0);
    check("rst_rd_en", lut_rd_en, 0);
    check("rst_status", {done, aborted, err, err_bank_mask}, 0);
    check("rst_wr_sum", wr_sum, 0);
    rst = 1'b1;
    tick();

    // ---- full table, bank 0, data = index ----
    clear_logs();
    do_start(12'd0, 13'd4096, 2'b01, 1'b0, c0);
    check("t1_busy", busy, 1);
    check("t1_sready", s_ready, 1);
    send("t1", 4096, 0, 1, 1'b0, k);
    check("t1_sready_after_last", s_ready, 0);
    wait_done(dc);
    check("t1_done_cyc", dc, k + 2);
    check("t1_wr_count", wr_addr_q.size(), 4096);
    errs = 0;
    foreach (wr_addr_q[i])
      if (wr_addr_q[i] != i || wr_data_q[i] != i || wr_mask_q[i] != 1) errs++;
    check("t1_wr_seq_errs", errs, 0);
    check("t1_last_wr_cyc", wr_cyc_q[wr_cyc_q.size()-1], k + 1);
    check("t1_wr_sum", wr_sum, 32'h007F_F800);

    // ---- wrap-around base, gapped stream ----
    clear_logs();
    do_start(12'd4094, 13'd4, 2'b10, 1'b0, c0);
    send("t2", 4, 16'hA000, 16'h0111, 1'b1, k);
    wait_done(dc);
    check("t2_done_cyc", dc, k + 2);
    check("t2_wr_count", wr_addr_q.size(), 4);
    errs = 0;
    foreach (wr_addr_q[i])
      if (wr_addr_q[i] != ((4094 + i) % 4096) || wr_data_q[i] != (16'hA000 + i * 16'h0111)
          || wr_mask_q[i] != 2) errs++;
    check("t2_wr_seq_errs", errs, 0);
    check("t2_wr_sum", wr_sum, 32'h0000_A000 + 32'h0000_A111 + 32'h0000_A222 + 32'h0000_A333);

    // ---- verify, both banks, clean memory ----
    clear_logs();
    do_start(12'd0, 13'd16, 2'b11, 1'b1, c0);
    send("t3", 16, 16'h1000, 16'h0101, 1'b0, k);
    wait_done(dc);
    check("t3_done_cyc", dc, k + 36);
    check("t3_rd_count", rd_bank_q.size(), 32);
    errs = 0;
    foreach (rd_bank_q[i])
      if (rd_bank_q[i] != (i / 16) || rd_addr_q[i] != (i % 16) || rd_cyc_q[i] != k + 2 + i) errs++;
    check("t3_rd_seq_errs", errs, 0);
    check("t3_err", {err, err_bank_mask}, 3'b000);

    // ---- verify with bank 1 address 5 corrupted ----
    clear_logs();
    corrupt = 1'b1;
    do_start(12'd0, 13'd16, 2'b11, 1'b1, c0);
    send("t4", 16, 16'h1000, 16'h0101, 1'b0, k);
    wait_done(dc);
    corrupt = 1'b0;
    check("t4_done_cyc", dc, k + 36);
    check("t4_err", {err, err_bank_mask}, 3'b110);

    // ---- abort after 100 beats; beat in abort cycle dropped ----
    clear_logs();
    do_start(12'd0, 13'd4096, 2'b01, 1'b0, c0);
    send("t5", 100, 16'h0200, 1, 1'b0, k);
    s_valid = 1'b1; s_data = 16'hDEAD; cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0; s_valid = 1'b0;
    check("t5_sready_after_abort", s_ready, 0);
    check("t5_busy_after_abort", busy, 0);
    check("t5_aborted", aborted, 1);
    tick(); tick(); tick();
    check("t5_wr_count", wr_addr_q.size(), 100);
    check("t5_no_done", done_q.size(), 0);
    do_start(12'd50, 13'd4, 2'b01, 1'b0, c0);
    check("t5_aborted_cleared", aborted, 0);
    send("t5b", 4, 16'h0010, 1, 1'b0, k);
    wait_done(dc);
    check("t5b_done_cyc", dc, k + 2);
    check("t5b_wr_count", wr_addr_q.size(), 104);

    // ---- zero length ----
    clear_logs();
    do_start(12'd7, 13'd0, 2'b11, 1'b1, c0);
    check("t6_busy", busy, 1);
    tick();
    check("t6_done_at_2", done, 1);
    check("t6_done_cyc", cyc - c0, 2);
    tick(); tick();
    check("t6_no_io", wr_addr_q.size() + rd_bank_q.size(), 0);

    // ---- start while busy is ignored ----
    clear_logs();
    do_start(12'd100, 13'd8, 2'b01, 1'b0, c0);
    send("t7a", 3, 16'h0300, 1, 1'b0, k);
    cfg_base = 12'd2000; cfg_len = 13'd2; cfg_bank_mask = 2'b10; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send("t7b", 5, 16'h0303, 1, 1'b0, k);
    wait_done(dc);
    check("t7_done_cyc", dc, k + 2);
    check("t7_wr_count", wr_addr_q.size(), 8);
    errs = 0;
    foreach (wr_addr_q[i])
      if (wr_addr_q[i] != 100 + i || wr_mask_q[i] != 1 || wr_data_q[i] != 16'h0300 + i) errs++;
    check("t7_wr_seq_errs", errs, 0);

    // ---- asynchronous reset mid-write ----
    clear_logs();
    do_start(12'd0, 13'd50, 2'b01, 1'b0, c0);
    send("t8", 10, 16'h0400, 1, 1'b0, k);
    s_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("t8_rst_wr_en", lut_wr_en, 0);
    check("t8_rst_busy_sready", {busy, s_ready}, 2'b00);
    check("t8_rst_wr_sum", wr_sum, 0);
    s_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    tick();
    clear_logs();
    do_start(12'd8, 13'd4, 2'b01, 1'b0, c0);
    send("t8b", 4, 16'h0500, 1, 1'b0, k);
    wait_done(dc);
    check("t8b_done_cyc", dc, k + 2);
    check("t8b_wr_count", wr_addr_q.size(), 4);
    check("t8b_wr_sum", wr_sum, 32'h0000_1406);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
